// File: rtl/pc_fetch_unit.sv
// Program counter and fetch/execute sequencer feeding the PC+4 adder and instruction memory.
// Define PC_MISALIGN_TRAP_EN to trap misaligned jump/branch targets to TRAP_VEC instead of aligning them.
//
// state  | meaning
// BOOT   | first cycle out of reset, outputs idle
// FETCH  | imem_req high, waiting for imem_ready
// EXEC   | instruction valid; PC advances on the unstalled exit edge
// HALTED | fetch stopped, only reset leaves
module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] TRAP_VEC = 32'h0000_0080
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] P4,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        jump,
   input  logic [31:0] jump_target,
   input  logic        stall,
   input  logic        halt,
   input  logic        imem_ready,
   output logic [31:0] PC,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   output logic        instr_valid
`ifdef PC_MISALIGN_TRAP_EN
   ,
   output logic        misalign
`endif
);

   typedef enum logic [1:0] {
      BOOT   = 2'd0,
      FETCH  = 2'd1,
      EXEC   = 2'd2,
      HALTED = 2'd3
   } state_t;

   state_t      state, state_nxt;
   logic [31:0] pc_nxt;
   logic [31:0] sel_pc;
`ifdef PC_MISALIGN_TRAP_EN
   logic        sel_is_tgt;
   logic        trap_nxt;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= BOOT;
         PC    <= RESET_PC;
      end else begin
         state <= state_nxt;
         PC    <= pc_nxt;
      end
   end

`ifdef PC_MISALIGN_TRAP_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) misalign <= 1'b0;
      else        misalign <= trap_nxt;
   end
`endif

   always_comb begin
      sel_pc = P4;
`ifdef PC_MISALIGN_TRAP_EN
      sel_is_tgt = 1'b0;
`endif
      if (jump) begin
         sel_pc = jump_target;
`ifdef PC_MISALIGN_TRAP_EN
         sel_is_tgt = 1'b1;
`endif
      end else if (br_taken) begin
         sel_pc = br_target;
`ifdef PC_MISALIGN_TRAP_EN
         sel_is_tgt = 1'b1;
`endif
      end
   end

   always_comb begin
      state_nxt = state;
      pc_nxt    = PC;
`ifdef PC_MISALIGN_TRAP_EN
      trap_nxt  = 1'b0;
`endif
      case (state)
         BOOT:  state_nxt = FETCH;
         FETCH: if (imem_ready) state_nxt = EXEC;
         EXEC: begin
            if (!stall) begin
               if (halt) begin
                  state_nxt = HALTED;
               end else begin
                  state_nxt = FETCH;
`ifdef PC_MISALIGN_TRAP_EN
                  // Only jump/branch targets are checked; P4 is trusted as delivered.
                  if (sel_is_tgt && (sel_pc[1:0] != 2'b00)) begin
                     pc_nxt   = TRAP_VEC;
                     trap_nxt = 1'b1;
                  end else begin
                     pc_nxt = sel_pc;
                  end
`else
                  pc_nxt = sel_pc & ~32'h0000_0003;
`endif
               end
            end
         end
         HALTED: state_nxt = HALTED;
         default: state_nxt = BOOT;
      endcase
   end

   // Decoded from the registered state, so async reset clears them at once.
   assign imem_req    = (state == FETCH);
   assign instr_valid = (state == EXEC);
   assign imem_addr   = PC;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: expected EXEC PCs are queued by the stimulus and
// popped by a monitor on each entry into EXEC; cycle-specific checks are made inline.
module tb_pc_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] P4;
   logic        br_taken;
   logic [31:0] br_target;
   logic        jump;
   logic [31:0] jump_target;
   logic        stall;
   logic        halt;
   logic        imem_ready;
   logic [31:0] PC;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        instr_valid;
`ifdef PC_MISALIGN_TRAP_EN
   logic        misalign;
`endif

   int n_vec = 0;
   int n_err = 0;
   logic [31:0] sb[$];
   logic        prev_iv = 1'b0;

   pc_fetch_unit dut (
      .clk(clk), .rst_n(rst_n), .P4(P4), .br_taken(br_taken), .br_target(br_target),
      .jump(jump), .jump_target(jump_target), .stall(stall), .halt(halt),
      .imem_ready(imem_ready), .PC(PC), .imem_req(imem_req), .imem_addr(imem_addr),
      .instr_valid(instr_valid)
`ifdef PC_MISALIGN_TRAP_EN
      , .misalign(misalign)
`endif
   );

   always #5 clk = ~clk;

   // Models the downstream PC+4 adder.
   assign P4 = PC + 32'd4;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitor: every entry into EXEC must present the next queued PC.
   always @(negedge clk) begin
      if (instr_valid === 1'b1 && !prev_iv) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL exec_unexpected: got PC %h, expected no instruction", PC);
         end else begin
            chk("exec_pc", PC, sb.pop_front());
         end
      end
      prev_iv = (instr_valid === 1'b1);
   end

   task automatic wait_fetch(input logic [31:0] addr);
      logic found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (imem_req && imem_addr == addr) found = 1'b1;
      end
      chk($sformatf("reach_fetch_%h", addr), {31'd0, found}, 32'd1);
   endtask

   task automatic wait_exec(input logic [31:0] addr);
      logic found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (instr_valid && PC == addr) found = 1'b1;
      end
      chk($sformatf("reach_exec_%h", addr), {31'd0, found}, 32'd1);
   endtask

   initial begin
      rst_n = 1'b0; imem_ready = 1'b1; br_taken = 1'b0; br_target = '0;
      jump = 1'b0; jump_target = '0; stall = 1'b0; halt = 1'b0;

      // Reset and boot
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_pc", PC, 32'h0);
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
`ifdef PC_MISALIGN_TRAP_EN
      chk("rst_misalign", {31'd0, misalign}, 32'd0);
`endif
      sb.push_back(32'h0); sb.push_back(32'h4); sb.push_back(32'h8); sb.push_back(32'hC);
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      chk("boot_req", {31'd0, imem_req}, 32'd0);
      @(negedge clk);
      chk("first_req", {31'd0, imem_req}, 32'd1);
      chk("first_addr", imem_addr, 32'h0);
      @(negedge clk);
      chk("first_valid", {31'd0, instr_valid}, 32'd1);

      // Memory wait at 0x10: ready low for three edges
      wait_fetch(32'h10);
      imem_ready = 1'b0;
      sb.push_back(32'h10);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("wait_req", {31'd0, imem_req}, 32'd1);
         chk("wait_addr", imem_addr, 32'h10);
      end
      imem_ready = 1'b1;
      sb.push_back(32'h14);
      wait_fetch(32'h14);

      // Priority: jump over branch, then branch alone
      sb.push_back(32'h18); sb.push_back(32'h1C); sb.push_back(32'h20);
      wait_exec(32'h20);
      jump = 1'b1; jump_target = 32'h100; br_taken = 1'b1; br_target = 32'h40;
      sb.push_back(32'h100);
      @(negedge clk);
      chk("prio_jump", imem_addr, 32'h100);
      jump = 1'b0;
      sb.push_back(32'h40);
      @(negedge clk);
      @(negedge clk);
      chk("prio_branch", imem_addr, 32'h40);
      br_taken = 1'b0;

      // Misaligned jump target
      @(negedge clk);
      jump = 1'b1; jump_target = 32'h102;
`ifdef PC_MISALIGN_TRAP_EN
      sb.push_back(32'h80);
      @(negedge clk);
      chk("misalign_pc", imem_addr, 32'h80);
      chk("misalign_pulse", {31'd0, misalign}, 32'd1);
`else
      sb.push_back(32'h100);
      @(negedge clk);
      chk("align_pc", imem_addr, 32'h100);
`endif
      jump_target = 32'hFFFF_FFFC;
      sb.push_back(32'hFFFF_FFFC);
      @(negedge clk);
`ifdef PC_MISALIGN_TRAP_EN
      chk("misalign_clear", {31'd0, misalign}, 32'd0);
`endif
      @(negedge clk);
      chk("wrap_high", imem_addr, 32'hFFFF_FFFC);
      jump = 1'b0;

      // Wrap through zero, then stall+halt at 0x4
      sb.push_back(32'h0); sb.push_back(32'h4);
      wait_exec(32'h4);
      stall = 1'b1; halt = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("stall_valid", {31'd0, instr_valid}, 32'd1);
         chk("stall_pc", PC, 32'h4);
      end
      stall = 1'b0;
      @(negedge clk);
      chk("halt_valid", {31'd0, instr_valid}, 32'd0);
      chk("halt_pc", PC, 32'h4);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("halt_req", {31'd0, imem_req}, 32'd0);
      end
      halt = 1'b0;

      // Reset out of HALTED
      rst_n = 1'b0;
      #1 chk("halt_rst_pc", PC, 32'h0);
      sb.push_back(32'h0); sb.push_back(32'h4);
      @(posedge clk); #1 rst_n = 1'b1;

      // Async reset while fetching 0x8
      wait_fetch(32'h8);
      #2 rst_n = 1'b0;
      #1;
      chk("async_req", {31'd0, imem_req}, 32'd0);
      chk("async_pc", PC, 32'h0);
      repeat (2) @(negedge clk);
      chk("sb_drained", sb.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: got no completion, expected finish");
      $fatal(1);
   end

endmodule
